fxp2fp_rr_arbiter: RTL and testbench

//  Shares one fixed-point to IEEE-754 single-precision converter core among NREQ requesters.

---
 rtl/fxp2fp_rr_arbiter_if.sv | 27 ++
 rtl/fxp2fp_rr_arbiter.sv | 130 +++++++++++++
 tb/tb_fxp2fp_rr_arbiter.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fxp2fp_rr_arbiter_if.sv
// Handshake bundle between fixed-point requesters and the shared
// fixed-to-float converter.
interface fxp2fp_rr_arbiter_if #(
    parameter int M    = 16,
    parameter int N    = 16,
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*(M+N)-1:0] req_data;
    logic [NREQ-1:0]       req_ready;
    logic                  out_valid;
    logic [31:0]           out_float;
    logic [IDW-1:0]        out_id;
    logic                  out_ready;
    logic                  busy;

    modport master (
        output req_valid, req_data, out_ready,
        input  req_ready, out_valid, out_float, out_id, busy
    );

    modport slave (
        input  req_valid, req_data, out_ready,
        output req_ready, out_valid, out_float, out_id, busy
    );
endinterface

// File: rtl/fxp2fp_rr_arbiter.sv
// Round-robin arbiter sharing one signed Q(M.N) to IEEE-754 single
// converter among NREQ requesters; one conversion in flight.
module fxp2fp_rr_arbiter #(
    parameter int M    = 16,
    parameter int N    = 16,
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fxp2fp_rr_arbiter_if.slave   bus
);
    localparam int W = M + N;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CONV = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;

    logic [1:0]     state_q, state_d;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic [W-1:0]   op_q, op_d;
    logic [IDW-1:0] id_q, id_d;
    logic [31:0]    out_float_q, out_float_d;
    logic [IDW-1:0] out_id_q, out_id_d;
    logic           out_valid_q, out_valid_d;

    logic           found;
    logic [IDW-1:0] gnt_id;
    logic [IDW-1:0] scan_idx;
    logic [NREQ-1:0] grant;

    logic           sign;
    logic [W-1:0]   mag;
    logic [W+22:0]  ext;
    logic [7:0]     exp_v;
    logic [22:0]    fract;
    logic [31:0]    conv;
    int             p;

    // Scan from rr_ptr upward, wrapping, and take the first valid request.
    always_comb begin
        found    = 1'b0;
        gnt_id   = '0;
        scan_idx = '0;
        grant    = '0;
        for (int i = 0; i < NREQ; i++) begin
            scan_idx = IDW'((int'(rr_ptr_q) + i) % NREQ);
            if (!found && bus.req_valid[scan_idx]) begin
                found  = 1'b1;
                gnt_id = scan_idx;
            end
        end
        if (found)
            grant[gnt_id] = 1'b1;
    end

    // Mantissa is truncated; the zero-padding covers narrow magnitudes.
    always_comb begin
        sign = op_q[W-1];
        mag  = sign ? (~op_q + W'(1)) : op_q;
        p    = 0;
        for (int i = 0; i < W; i++)
            if (mag[i])
                p = i;
        ext   = {mag, 23'b0} << (W - 1 - p);
        fract = ext[W+21 -: 23];
        exp_v = 8'(p - N + 127);
        conv  = (mag == '0) ? 32'h0 : {sign, exp_v, fract};
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        op_d        = op_q;
        id_d        = id_q;
        out_float_d = out_float_q;
        out_id_d    = out_id_q;
        out_valid_d = out_valid_q;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    op_d     = bus.req_data[int'(gnt_id)*W +: W];
                    id_d     = gnt_id;
                    rr_ptr_d = IDW'((int'(gnt_id) + 1) % NREQ);
                    state_d  = CONV;
                end
            end
            CONV: begin
                out_float_d = conv;
                out_id_d    = id_q;
                out_valid_d = 1'b1;
                state_d     = HOLD;
            end
            HOLD: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            op_q        <= '0;
            id_q        <= '0;
            out_float_q <= '0;
            out_id_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            op_q        <= op_d;
            id_q        <= id_d;
            out_float_q <= out_float_d;
            out_id_q    <= out_id_d;
            out_valid_q <= out_valid_d;
        end
    end

    // No grant is offered while reset is asserted.
    assign bus.req_ready = (state_q == IDLE && rst_n) ? grant : '0;
    assign bus.out_valid = out_valid_q;
    assign bus.out_float = out_float_q;
    assign bus.out_id    = out_id_q;
    assign bus.busy      = (state_q == CONV) || (state_q == HOLD);
endmodule

// File: tb/tb_fxp2fp_rr_arbiter.sv
// Directed bench for the round-robin fixed-to-float arbiter.
module tb_fxp2fp_rr_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    fxp2fp_rr_arbiter_if #(.M(16), .N(16), .NREQ(4)) bus ();

    fxp2fp_rr_arbiter #(.M(16), .N(16), .NREQ(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.req_valid = 4'b0000;
        bus.req_data  = '0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        bus.req_valid = 4'b1111;
        #1;
        total++;
        if (bus.req_ready !== 4'b0000) begin
            bad++;
            $display("FAIL reset_ready got=%b want=0000", bus.req_ready);
        end
        total++;
        if ({bus.out_valid, bus.busy} !== 2'b00) begin
            bad++;
            $display("FAIL reset_valid_busy got=%b want=00",
                     {bus.out_valid, bus.busy});
        end
        total++;
        if (bus.out_float !== 32'h0 || bus.out_id !== 2'd0) begin
            bad++;
            $display("FAIL reset_out got=%h/%0d want=0/0",
                     bus.out_float, bus.out_id);
        end
        bus.req_valid = 4'b0000;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic convert_one(input int k, input logic [31:0] x,
                               input logic [31:0] want, input string nm);
        logic [3:0] oh;
        oh = 4'b0001 << k;
        bus.req_valid = oh;
        bus.req_data  = '0;
        bus.req_data[k*32 +: 32] = x;
        #1;
        total++;
        if (bus.req_ready !== oh) begin
            bad++;
            $display("FAIL %s_grant got=%b want=%b", nm, bus.req_ready, oh);
        end
        tick();
        bus.req_valid = 4'b0000;
        bus.req_data  = '1;
        #1;
        total++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b1) begin
            bad++;
            $display("FAIL %s_conv got=v%b b%b want=v0 b1",
                     nm, bus.out_valid, bus.busy);
        end
        tick();
        total++;
        if (bus.out_valid !== 1'b1 || bus.out_float !== want ||
            bus.out_id !== 2'(k)) begin
            bad++;
            $display("FAIL %s_result got=v%b %h id%0d want=v1 %h id%0d",
                     nm, bus.out_valid, bus.out_float, bus.out_id, want, k);
        end
        bus.out_ready = 1'b1;
        tick();
        total++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL %s_release got=v%b b%b want=v0 b0",
                     nm, bus.out_valid, bus.busy);
        end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_values();
        convert_one(0, 32'h0001_0000, 32'h3F80_0000, "one");
        convert_one(1, 32'hFFFF_0000, 32'hBF80_0000, "neg_one");
        convert_one(2, 32'h0001_8000, 32'h3FC0_0000, "one_half");
        convert_one(3, 32'h0000_0001, 32'h3780_0000, "lsb");
        convert_one(0, 32'h0000_0000, 32'h0000_0000, "zero");
        convert_one(1, 32'h8000_0000, 32'hC700_0000, "most_neg");
        convert_one(2, 32'h7FFF_FFFF, 32'h46FF_FFFF, "most_pos");
    endtask

    task automatic test_round_robin();
        logic [31:0] fl [4];
        fl[0] = 32'h3F80_0000;
        fl[1] = 32'h4000_0000;
        fl[2] = 32'h4040_0000;
        fl[3] = 32'h4080_0000;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++)
            bus.req_data[k*32 +: 32] = 32'(k + 1) << 16;
        bus.req_valid = 4'b1111;
        bus.out_ready = 1'b1;
        #1;
        for (int g = 0; g < 8; g++) begin
            total++;
            if (bus.req_ready !== (4'b0001 << (g % 4))) begin
                bad++;
                $display("FAIL rr_grant%0d got=%b want=%b", g,
                         bus.req_ready, 4'b0001 << (g % 4));
            end
            tick();
            total++;
            if (bus.req_ready !== 4'b0000) begin
                bad++;
                $display("FAIL rr_conv_ready%0d got=%b want=0000",
                         g, bus.req_ready);
            end
            tick();
            total++;
            if (bus.out_valid !== 1'b1 || bus.out_id !== 2'(g % 4) ||
                bus.out_float !== fl[g % 4] || bus.req_ready !== 4'b0000) begin
                bad++;
                $display("FAIL rr_out%0d got=v%b id%0d %h r%b want=v1 id%0d %h r0000",
                         g, bus.out_valid, bus.out_id, bus.out_float,
                         bus.req_ready, g % 4, fl[g % 4]);
            end
            tick();
        end
        bus.req_valid = 4'b0000;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_hold();
        int errs;
        bus.req_data[31:0] = 32'h0001_8000;
        bus.req_valid = 4'b0001;
        #1;
        total++;
        if (bus.req_ready !== 4'b0001) begin
            bad++;
            $display("FAIL hold_grant got=%b want=0001", bus.req_ready);
        end
        tick();
        bus.req_valid = 4'b1111;
        tick();
        errs = 0;
        for (int c = 0; c < 10; c++) begin
            if (bus.out_valid !== 1'b1 || bus.out_float !== 32'h3FC0_0000 ||
                bus.out_id !== 2'd0 || bus.req_ready !== 4'b0000)
                errs++;
            tick();
        end
        total++;
        if (errs != 0) begin
            bad++;
            $display("FAIL hold_stable got=%0d bad cycles want=0", errs);
        end
        bus.out_ready = 1'b1;
        tick();
        total++;
        if (bus.out_valid !== 1'b0 || bus.req_ready !== 4'b0010) begin
            bad++;
            $display("FAIL hold_next got=v%b r%b want=v0 r0010",
                     bus.out_valid, bus.req_ready);
        end
        bus.req_valid = 4'b0000;
        bus.out_ready = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        bus.req_data[95:64] = 32'h0001_0000;
        bus.req_valid = 4'b0100;
        #1;
        total++;
        if (bus.req_ready !== 4'b0100) begin
            bad++;
            $display("FAIL mid_grant got=%b want=0100", bus.req_ready);
        end
        tick();
        bus.req_valid = 4'b0000;
        rst_n = 1'b0;
        tick();
        total++;
        if (bus.out_valid !== 1'b0 || bus.req_ready !== 4'b0000 ||
            bus.busy !== 1'b0 || bus.out_float !== 32'h0) begin
            bad++;
            $display("FAIL mid_reset got=v%b r%b b%b %h want=v0 r0000 b0 0",
                     bus.out_valid, bus.req_ready, bus.busy, bus.out_float);
        end
        rst_n = 1'b1;
        bus.req_data[31:0]   = 32'hFFFF_0000;
        bus.req_data[127:96] = 32'h0001_0000;
        bus.req_valid = 4'b1001;
        #1;
        total++;
        if (bus.req_ready !== 4'b0001) begin
            bad++;
            $display("FAIL mid_ptr got=%b want=0001", bus.req_ready);
        end
        tick();
        bus.req_valid = 4'b0000;
        tick();
        total++;
        if (bus.out_valid !== 1'b1 || bus.out_id !== 2'd0 ||
            bus.out_float !== 32'hBF80_0000) begin
            bad++;
            $display("FAIL mid_result got=v%b id%0d %h want=v1 id0 bf800000",
                     bus.out_valid, bus.out_id, bus.out_float);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    initial begin
        bus.req_valid = 4'b0000;
        bus.req_data  = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_values();
        test_round_robin();
        test_hold();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
